jk_bank_arbiter: RTL and testbench

Shared bank of N behavioural JK flip-flops, accessed by two independent requesters (A, B) through valid/ready command ports. An arbiter grants one command at a time. A three-state sequencer applies the JK operation to the selected flop and returns a completion pulse carrying the flop's new value. The block sits between control logic that needs individually addressable set/reset/toggle flags and the flop bank that holds them.

---
 rtl/jk_bank_arbiter_if.sv | 25 ++
 rtl/jk_bank_arbiter.sv | 109 ++++++++++
 tb/tb_jk_bank_arbiter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/jk_bank_arbiter_if.sv
// rtl/jk_bank_arbiter_if.sv - command handshake bundle for the two requesters of jk_bank_arbiter
interface jk_bank_arbiter_if #(
  parameter int IDXW = 3
);
  logic            a_valid;
  logic            a_ready;
  logic [1:0]      a_op;
  logic [IDXW-1:0] a_idx;
  logic            b_valid;
  logic            b_ready;
  logic [1:0]      b_op;
  logic [IDXW-1:0] b_idx;

  // Requester side drives commands and observes ready.
  modport master (
    output a_valid, a_op, a_idx, b_valid, b_op, b_idx,
    input  a_ready, b_ready
  );

  // Arbiter side accepts commands and drives ready.
  modport slave (
    input  a_valid, a_op, a_idx, b_valid, b_op, b_idx,
    output a_ready, b_ready
  );
endinterface

// File: rtl/jk_bank_arbiter.sv
// rtl/jk_bank_arbiter.sv - two-port arbitrated JK flop bank; define JK_BANK_RR_EN for round-robin, else fixed A priority
module jk_bank_arbiter #(
  parameter int N    = 8,
  parameter int IDXW = 3
) (
  input  logic                clk,
  input  logic                rst,
  jk_bank_arbiter_if.slave    cmd,
  output logic [N-1:0]        q,
  output logic [N-1:0]        qbar,
  output logic                busy,
  output logic                done,
  output logic                done_src,
  output logic                done_q,
  output logic                err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic            prio;      // 0 = A wins a tie, 1 = B wins a tie
  logic            accept;
  logic            grant_b;
  logic [1:0]      op_r;
  logic [IDXW-1:0] idx_r;
  logic            src_r;
  logic            in_range;

  // Extra top bit so N = 2^IDXW still compares correctly.
  assign in_range = ({1'b0, idx_r} < (IDXW+1)'(N));
  assign accept   = cmd.a_ready | cmd.b_ready;
  assign grant_b  = cmd.b_ready;
  assign qbar     = ~q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state: only IDLE waits, on an accepted command.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = APPLY;
      APPLY:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs: readiness only in IDLE and never while reset is held; response fields only in RESP.
  always_comb begin
    cmd.a_ready = 1'b0;
    cmd.b_ready = 1'b0;
    if (state == IDLE && !rst) begin
      cmd.a_ready = cmd.a_valid && (!cmd.b_valid || !prio);
      cmd.b_ready = cmd.b_valid && (!cmd.a_valid ||  prio);
    end
    busy     = (state != IDLE);
    done     = (state == RESP);
    done_src = done && src_r;
    err      = done && !in_range;
    done_q   = done && in_range && q[idx_r];
  end

`ifdef JK_BANK_RR_EN
  // Tie priority passes to whichever requester was not just granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         prio <= 1'b0;
    else if (accept) prio <= ~grant_b;
  end
`else
  assign prio = 1'b0;
`endif

  // Capture the granted command so later requester changes cannot disturb it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r  <= 2'b00;
      idx_r <= '0;
      src_r <= 1'b0;
    end else if (accept) begin
      op_r  <= grant_b ? cmd.b_op  : cmd.a_op;
      idx_r <= grant_b ? cmd.b_idx : cmd.a_idx;
      src_r <= grant_b;
    end
  end

  // Flop bank: the latched JK op lands on the target at the APPLY edge; out-of-range targets are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (state == APPLY && in_range) begin
      case (op_r)
        2'b01:   q[idx_r] <= 1'b0;
        2'b10:   q[idx_r] <= 1'b1;
        2'b11:   q[idx_r] <= ~q[idx_r];
        default: q[idx_r] <= q[idx_r];
      endcase
    end
  end

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// tb/tb_jk_bank_arbiter.sv - self-checking bench for jk_bank_arbiter against a bit-vector reference model
module tb_jk_bank_arbiter;

`ifdef JK_BANK_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jk_bank_arbiter_if #(.IDXW(3)) bus  ();
  jk_bank_arbiter_if #(.IDXW(3)) bus6 ();

  logic [7:0] q, qbar;
  logic       busy, done, done_src, done_q, err;
  logic [5:0] q6, qbar6;
  logic       busy6, done6, done_src6, done_q6, err6;

  jk_bank_arbiter #(.N(8), .IDXW(3)) dut (
    .clk(clk), .rst(rst), .cmd(bus),
    .q(q), .qbar(qbar), .busy(busy), .done(done),
    .done_src(done_src), .done_q(done_q), .err(err)
  );

  jk_bank_arbiter #(.N(6), .IDXW(3)) dut6 (
    .clk(clk), .rst(rst), .cmd(bus6),
    .q(q6), .qbar(qbar6), .busy(busy6), .done(done6),
    .done_src(done_src6), .done_q(done_q6), .err(err6)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [7:0] m_q;

  function automatic logic [7:0] jk_apply(input logic [7:0] v, input logic [1:0] op, input int idx);
    logic [7:0] m;
    m = 8'(1) << idx;
    case (op)
      2'b01:   return v & ~m;
      2'b10:   return v | m;
      2'b11:   return v ^ m;
      default: return v;
    endcase
  endfunction

  task automatic idle_inputs();
    bus.a_valid = 0; bus.a_op = 0; bus.a_idx = 0;
    bus.b_valid = 0; bus.b_op = 0; bus.b_idx = 0;
    bus6.a_valid = 0; bus6.a_op = 0; bus6.a_idx = 0;
    bus6.b_valid = 0; bus6.b_op = 0; bus6.b_idx = 0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1; idle_inputs();
    @(negedge clk); rst = 0;
    m_q = 8'h00;
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1; bus.a_valid = 1; bus.b_valid = 1; #1;
    total_cnt++; if (q !== 8'h00)     $display("FAIL reset_q got=%h exp=00", q); else pass_cnt++;
    total_cnt++; if (qbar !== 8'hff)  $display("FAIL reset_qbar got=%h exp=ff", qbar); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0)   $display("FAIL reset_busy got=%b exp=0", busy); else pass_cnt++;
    total_cnt++; if ({done, done_src, done_q, err} !== 4'b0) $display("FAIL reset_resp got=%b exp=0000", {done, done_src, done_q, err}); else pass_cnt++;
    total_cnt++; if ({bus.a_ready, bus.b_ready} !== 2'b00) $display("FAIL reset_ready got=%b exp=00", {bus.a_ready, bus.b_ready}); else pass_cnt++;
    @(negedge clk); idle_inputs(); rst = 0;
    m_q = 8'h00;
  endtask

  task automatic test_set_a();
    @(negedge clk); bus.a_valid = 1; bus.a_op = 2'b10; bus.a_idx = 3; #1;
    total_cnt++; if ({bus.a_ready, bus.b_ready} !== 2'b10) $display("FAIL set_ready got=%b exp=10", {bus.a_ready, bus.b_ready}); else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++; if (bus.a_ready !== 1'b0) $display("FAIL set_ready_apply got=%b exp=0", bus.a_ready); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1 || done !== 1'b0) $display("FAIL set_apply_state busy=%b done=%b exp busy=1 done=0", busy, done); else pass_cnt++;
    total_cnt++; if (q !== 8'h00) $display("FAIL set_q_apply got=%h exp=00", q); else pass_cnt++;
    bus.a_valid = 0;
    @(negedge clk); #1;
    total_cnt++; if (q !== 8'h08) $display("FAIL set_q got=%h exp=08", q); else pass_cnt++;
    total_cnt++; if ({done, done_src, done_q, err} !== 4'b1010) $display("FAIL set_resp got=%b exp=1010", {done, done_src, done_q, err}); else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL set_after done=%b busy=%b exp 0 0", done, busy); else pass_cnt++;
    m_q = 8'h08;
  endtask

  task automatic test_toggle_pair();
    for (int i = 0; i < 2; i++) begin
      bit src;
      int n;
      logic exp_dq;
      src = (i == 0);
      @(negedge clk);
      if (src) begin bus.b_valid = 1; bus.b_op = 2'b11; bus.b_idx = 3; end
      else     begin bus.a_valid = 1; bus.a_op = 2'b11; bus.a_idx = 3; end
      n = 0; #1;
      while (!(src ? bus.b_ready : bus.a_ready) && n < 10) begin @(negedge clk); #1; n++; end
      total_cnt++; if (n >= 10) $display("FAIL toggle_accept_timeout got=%0d exp<10", n); else pass_cnt++;
      m_q = jk_apply(m_q, 2'b11, 3);
      exp_dq = m_q[3];
      @(negedge clk); bus.a_valid = 0; bus.b_valid = 0;
      n = 0; #1;
      while (!done && n < 10) begin @(negedge clk); #1; n++; end
      total_cnt++; if (done !== 1'b1) $display("FAIL toggle_done_timeout got=%b exp=1", done); else pass_cnt++;
      total_cnt++; if (done_src !== src || done_q !== exp_dq) $display("FAIL toggle_resp src=%b dq=%b exp src=%b dq=%b", done_src, done_q, src, exp_dq); else pass_cnt++;
      total_cnt++; if (q !== m_q) $display("FAIL toggle_q got=%h exp=%h", q, m_q); else pass_cnt++;
    end
  endtask

  task automatic test_contention();
    int grants[$];
    int cycles[$];
    pulse_reset();
    @(negedge clk);
    bus.a_valid = 1; bus.a_op = 2'b10; bus.a_idx = 1;
    bus.b_valid = 1; bus.b_op = 2'b11; bus.b_idx = 5;
    for (int c = 0; c < 12; c++) begin
      #1;
      total_cnt++; if (bus.a_ready && bus.b_ready) $display("FAIL cont_both_ready got=11 exp=not both"); else pass_cnt++;
      if (busy) begin
        total_cnt++; if (bus.a_ready || bus.b_ready) $display("FAIL cont_ready_busy got=%b exp=00", {bus.a_ready, bus.b_ready}); else pass_cnt++;
      end
      if (bus.a_ready) begin grants.push_back(0); cycles.push_back(c); end
      if (bus.b_ready) begin grants.push_back(1); cycles.push_back(c); end
      @(negedge clk);
    end
    idle_inputs();
    total_cnt++; if (grants.size() != 4) $display("FAIL cont_grant_count got=%0d exp=4", grants.size()); else pass_cnt++;
    for (int g = 0; g < grants.size(); g++) begin
      int exp_g;
      exp_g = RR ? (g % 2) : 0;
      total_cnt++; if (grants[g] != exp_g) $display("FAIL cont_grant_%0d got=%0d exp=%0d", g, grants[g], exp_g); else pass_cnt++;
      if (g > 0) begin
        total_cnt++; if (cycles[g] - cycles[g-1] != 3) $display("FAIL cont_gap_%0d got=%0d exp=3", g, cycles[g] - cycles[g-1]); else pass_cnt++;
      end
    end
    @(negedge clk); @(negedge clk);
    m_q = q;
  endtask

  task automatic test_out_of_range();
    @(negedge clk); bus6.a_valid = 1; bus6.a_op = 2'b10; bus6.a_idx = 7; #1;
    total_cnt++; if (bus6.a_ready !== 1'b1) $display("FAIL oor_ready got=%b exp=1", bus6.a_ready); else pass_cnt++;
    @(negedge clk); bus6.a_valid = 0; #1;
    total_cnt++; if (busy6 !== 1'b1) $display("FAIL oor_busy got=%b exp=1", busy6); else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++; if ({done6, done_src6, done_q6, err6} !== 4'b1001) $display("FAIL oor_resp got=%b exp=1001", {done6, done_src6, done_q6, err6}); else pass_cnt++;
    total_cnt++; if (q6 !== 6'h00) $display("FAIL oor_q got=%h exp=00", q6); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int n;
    @(negedge clk); bus.a_valid = 1; bus.a_op = 2'b10; bus.a_idx = 0; #1;
    total_cnt++; if (bus.a_ready !== 1'b1) $display("FAIL mid_ready got=%b exp=1", bus.a_ready); else pass_cnt++;
    @(negedge clk); bus.a_valid = 0; #1;
    total_cnt++; if (busy !== 1'b1) $display("FAIL mid_busy_apply got=%b exp=1", busy); else pass_cnt++;
    rst = 1; #1;
    total_cnt++; if (q !== 8'h00 || qbar !== 8'hff) $display("FAIL mid_q got=%h/%h exp=00/ff", q, qbar); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL mid_busy got=%b exp=0", busy); else pass_cnt++;
    n = 0;
    for (int c = 0; c < 3; c++) begin @(negedge clk); #1; if (done) n++; end
    total_cnt++; if (n != 0) $display("FAIL mid_no_done got=%0d exp=0", n); else pass_cnt++;
    rst = 0;
    @(negedge clk); bus.a_valid = 1; bus.a_op = 2'b10; bus.a_idx = 0; #1;
    total_cnt++; if (bus.a_ready !== 1'b1) $display("FAIL mid_regrant got=%b exp=1", bus.a_ready); else pass_cnt++;
    @(negedge clk); bus.a_valid = 0;
    @(negedge clk); #1;
    total_cnt++; if (done !== 1'b1 || done_q !== 1'b1 || q !== 8'h01) $display("FAIL mid_resp done=%b dq=%b q=%h exp 1 1 01", done, done_q, q); else pass_cnt++;
    @(negedge clk);
    m_q = 8'h01;
  endtask

  task automatic test_random();
    int   phase;
    bit   m_prio;
    bit   p_src;
    logic [1:0] p_op;
    int   p_idx;
    pulse_reset();
    m_prio = 0; phase = 0;
    for (int c = 0; c < 400; c++) begin
      logic exp_a, exp_b;
      @(negedge clk);
      bus.a_valid = ($urandom_range(0, 3) != 0);
      bus.b_valid = ($urandom_range(0, 3) != 0);
      bus.a_op = 2'($urandom_range(0, 3)); bus.a_idx = 3'($urandom_range(0, 7));
      bus.b_op = 2'($urandom_range(0, 3)); bus.b_idx = 3'($urandom_range(0, 7));
      #1;
      exp_a = (phase == 0) && bus.a_valid && (!bus.b_valid || !m_prio);
      exp_b = (phase == 0) && bus.b_valid && (!bus.a_valid ||  m_prio);
      total_cnt++; if ({bus.a_ready, bus.b_ready} !== {exp_a, exp_b}) $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, {bus.a_ready, bus.b_ready}, {exp_a, exp_b}); else pass_cnt++;
      total_cnt++; if (busy !== (phase != 0) || done !== (phase == 2)) $display("FAIL rnd_state c=%0d busy=%b done=%b exp phase=%0d", c, busy, done, phase); else pass_cnt++;
      total_cnt++; if (q !== m_q || qbar !== ~m_q) $display("FAIL rnd_q c=%0d got=%h exp=%h", c, q, m_q); else pass_cnt++;
      if (phase == 2) begin
        total_cnt++; if ({done_src, done_q, err} !== {p_src, m_q[p_idx], 1'b0}) $display("FAIL rnd_resp c=%0d got=%b exp=%b", c, {done_src, done_q, err}, {p_src, m_q[p_idx], 1'b0}); else pass_cnt++;
      end
      case (phase)
        0: if (exp_a || exp_b) begin
             p_src = exp_b;
             p_op  = exp_b ? bus.b_op : bus.a_op;
             p_idx = exp_b ? int'(bus.b_idx) : int'(bus.a_idx);
             if (RR) m_prio = !exp_b;
             phase = 1;
           end
        1: begin m_q = jk_apply(m_q, p_op, p_idx); phase = 2; end
        default: phase = 0;
      endcase
    end
    @(negedge clk); idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    m_q = 8'h00;
    test_reset();
    test_set_a();
    test_toggle_pair();
    test_contention();
    test_out_of_range();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
